// File: rtl/sev_display_driver.sv
`default_nettype none
// ============================================================================
// Module   : sev_display_driver
// Brief    : 4-digit multiplexed seven-segment driver with guard blanking,
//            per-frame snapshots and optional leading-zero suppression.
// Revision : 1.0 - initial release
// ============================================================================
module sev_display_driver #(
    parameter int SCAN_DIV = 100000,
    parameter int GUARD    = 1000
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [15:0] value,
    input  logic [3:0]  dp_en,
    input  logic        blank_lz,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  scan,
    output logic        frame_done
);

    localparam int                 c_CNT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(SCAN_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_GUARD   = c_CNT_W'(GUARD);

    logic [c_CNT_W-1:0] r_cnt;
    logic [1:0]         r_digit;
    logic [15:0]        r_snap;
    logic [3:0]         r_lz_mask;
    logic [6:0]         r_seg;
    logic               r_dp;
    logic [3:0]         r_scan;
    logic               r_frame_done;

    logic               w_slot_end;
    logic               w_frame_start;
    logic               w_show;
    logic [3:0]         w_nibble;
    logic [3:0]         w_lz_next;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign w_slot_end    = (r_cnt == c_CNT_MAX);
    assign w_frame_start = (r_cnt == '0) && (r_digit == 2'd0);
    assign w_show        = (r_cnt >= c_GUARD);

    // A digit is blanked when it and every digit to its left are zero.
    assign w_lz_next = {4{blank_lz}} & {
        (value[15:12] == 4'h0),
        (value[15:8]  == 8'h00),
        (value[15:4]  == 12'h000),
        1'b0
    };

    always_comb begin
        w_nibble = r_snap[3:0];
        case (r_digit)
            2'd0:    w_nibble = r_snap[3:0];
            2'd1:    w_nibble = r_snap[7:4];
            2'd2:    w_nibble = r_snap[11:8];
            default: w_nibble = r_snap[15:12];
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_cnt   <= '0;
            r_digit <= 2'd0;
        end else if (w_slot_end) begin
            r_cnt   <= '0;
            r_digit <= r_digit + 2'd1;
        end else begin
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_snap    <= 16'h0000;
            r_lz_mask <= 4'h0;
        end else if (w_frame_start) begin
            r_snap    <= value;
            r_lz_mask <= w_lz_next;
        end
    end

    // Outputs follow the slot position one cycle late; dp_en is deliberately live.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_seg        <= 7'h7F;
            r_dp         <= 1'b1;
            r_scan       <= 4'hF;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_slot_end && (r_digit == 2'd3);
            if (w_show) begin
                r_scan <= ~(4'b0001 << r_digit);
                if (r_lz_mask[r_digit]) begin
                    r_seg <= 7'h7F;
                    r_dp  <= 1'b1;
                end else begin
                    r_seg <= hex_to_seg(w_nibble);
                    r_dp  <= ~dp_en[r_digit];
                end
            end else begin
                r_scan <= 4'hF;
                r_seg  <= 7'h7F;
                r_dp   <= 1'b1;
            end
        end
    end

    assign seg        = r_seg;
    assign dp         = r_dp;
    assign scan       = r_scan;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_sev_display_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_sev_display_driver
// Brief    : Self-checking bench: vector table, directed corner sequences and
//            randomized traffic against a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sev_display_driver;

    localparam int SD = 8;
    localparam int GD = 2;
    localparam int FRAME = 4 * SD;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [15:0] value = 16'h0000;
    logic [3:0]  dp_en = 4'h0;
    logic        blank_lz = 1'b0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  scan;
    logic        frame_done;

    sev_display_driver #(.SCAN_DIV(SD), .GUARD(GD)) dut (
        .clk        (clk),
        .clr        (clr),
        .value      (value),
        .dp_en      (dp_en),
        .blank_lz   (blank_lz),
        .seg        (seg),
        .dp         (dp),
        .scan       (scan),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: elapsed cycles since reset plus the frame snapshot.
    int          m_t     = 0;
    bit          m_valid = 1'b0;
    logic [15:0] m_snap  = 16'h0000;
    logic        m_blz   = 1'b0;

    logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    typedef struct {
        logic [15:0] val;
        logic        blz;
        logic [3:0]  dpe;
        int          digit;
        logic [6:0]  exp_seg;
        logic        exp_dp;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0d)", name, act, exp, $time);
        end
    endtask

    function automatic int sig_digits(input logic [15:0] v);
        int n = 1;
        for (int i = 1; i < 4; i++)
            if (v[4*i +: 4] != 4'h0) n = i + 1;
        return n;
    endfunction

    task automatic step();
        logic [6:0] e_seg;
        logic       e_dp;
        logic [3:0] e_scan;
        logic       e_fd;
        int         pos;
        int         dig;
        logic [3:0] nib;
        @(posedge clk);
        e_seg = 7'h7F; e_dp = 1'b1; e_scan = 4'hF; e_fd = 1'b0;
        if (clr) begin
            m_t = 0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            if (m_t % FRAME == 0) begin
                m_snap = value;
                m_blz  = blank_lz;
            end
            pos  = m_t % SD;
            dig  = (m_t / SD) % 4;
            e_fd = ((m_t % FRAME) == FRAME - 1);
            if (pos >= GD) begin
                e_scan = 4'hF;
                e_scan[dig] = 1'b0;
                if (!(m_blz && dig >= sig_digits(m_snap))) begin
                    nib   = m_snap[4*dig +: 4];
                    e_seg = hex_tab[nib];
                    e_dp  = ~dp_en[dig];
                end
            end
            m_t++;
        end
        #1;
        if (m_valid) begin
            check("model_seg", {25'd0, seg}, {25'd0, e_seg});
            check("model_dp", {31'd0, dp}, {31'd0, e_dp});
            check("model_scan", {28'd0, scan}, {28'd0, e_scan});
            check("model_frame_done", {31'd0, frame_done}, {31'd0, e_fd});
        end
        check("one_anode_max", {31'd0, ($countones(~scan) <= 1)}, 32'd1);
    endtask

    task automatic run_until(input int tt);
        int guard = 0;
        while (m_t <= tt && guard < 10000) begin
            step();
            guard++;
        end
        if (guard >= 10000) check("run_until_timeout", 32'd1, 32'd0);
    endtask

    task automatic do_reset();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    logic [3:0] t1_scan [10] = '{4'hF, 4'hF, 4'hE, 4'hE, 4'hE, 4'hE, 4'hE, 4'hE, 4'hF, 4'hF};

    initial begin
        vecs[0]  = '{16'h12AF, 1'b0, 4'h0, 0, 7'h0E, 1'b1};
        vecs[1]  = '{16'h12AF, 1'b0, 4'h0, 1, 7'h08, 1'b1};
        vecs[2]  = '{16'h12AF, 1'b0, 4'h0, 2, 7'h24, 1'b1};
        vecs[3]  = '{16'h12AF, 1'b0, 4'h0, 3, 7'h79, 1'b1};
        vecs[4]  = '{16'h0005, 1'b1, 4'h0, 0, 7'h12, 1'b1};
        vecs[5]  = '{16'h0005, 1'b1, 4'h0, 1, 7'h7F, 1'b1};
        vecs[6]  = '{16'h0005, 1'b1, 4'h0, 3, 7'h7F, 1'b1};
        vecs[7]  = '{16'h0000, 1'b1, 4'h0, 0, 7'h40, 1'b1};
        vecs[8]  = '{16'h0000, 1'b1, 4'h0, 2, 7'h7F, 1'b1};
        vecs[9]  = '{16'h0000, 1'b0, 4'h0, 3, 7'h40, 1'b1};
        vecs[10] = '{16'h12AF, 1'b0, 4'h4, 2, 7'h24, 1'b0};
        vecs[11] = '{16'h12AF, 1'b0, 4'h4, 1, 7'h08, 1'b1};
        vecs[12] = '{16'h0005, 1'b1, 4'hF, 2, 7'h7F, 1'b1};
        vecs[13] = '{16'h0005, 1'b1, 4'hF, 0, 7'h12, 1'b0};

        // Reset state and release sequence
        clr = 1'b1;
        step();
        step();
        check("reset_seg", {25'd0, seg}, 32'h7F);
        check("reset_dp", {31'd0, dp}, 32'd1);
        check("reset_scan", {28'd0, scan}, 32'hF);
        check("reset_frame_done", {31'd0, frame_done}, 32'd0);
        clr = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("release_scan", {28'd0, scan}, {28'd0, t1_scan[i]});
        end

        // Vector table
        for (int i = 0; i < 14; i++) begin
            value    = vecs[i].val;
            blank_lz = vecs[i].blz;
            dp_en    = vecs[i].dpe;
            do_reset();
            run_until(vecs[i].digit * SD + GD + 1);
            check("vec_seg", {25'd0, seg}, {25'd0, vecs[i].exp_seg});
            check("vec_dp", {31'd0, dp}, {31'd0, vecs[i].exp_dp});
            check("vec_scan", {28'd0, scan}, {28'd0, ~(4'b0001 << vecs[i].digit)});
        end

        // Tear-free: change the value during digit1 SHOW
        value = 16'h1111; blank_lz = 1'b0; dp_en = 4'h0;
        do_reset();
        run_until(10);
        value = 16'h2222;
        run_until(26);
        check("tearfree_old_frame", {25'd0, seg}, 32'h79);
        run_until(FRAME + 26);
        check("tearfree_new_frame", {25'd0, seg}, 32'h24);

        // Reset during digit2 SHOW
        value = 16'h1234;
        do_reset();
        run_until(19);
        clr = 1'b1;
        step();
        check("midreset_scan", {28'd0, scan}, 32'hF);
        check("midreset_seg", {25'd0, seg}, 32'h7F);
        check("midreset_frame_done", {31'd0, frame_done}, 32'd0);
        value = 16'h5678;
        clr = 1'b0;
        run_until(3);
        check("midreset_resnap_seg", {25'd0, seg}, 32'h00);
        check("midreset_resnap_scan", {28'd0, scan}, 32'hE);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                logic [15:0] v;
                v = 16'($urandom);
                for (int k = 0; k < 4; k++)
                    if ($urandom_range(0, 1) == 1) v[4*k +: 4] = 4'h0;
                value = v;
            end
            if ($urandom_range(0, 39) == 0) blank_lz = 1'($urandom);
            if ($urandom_range(0, 9) == 0)  dp_en = 4'($urandom);
            clr = ($urandom_range(0, 199) == 0);
            step();
        end
        clr = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
